// File: rtl/vertical_chain_ctrl_if.sv
// Scheduler/node-pin bundle for one vertical adder column sequencer.
// master = scheduler side driving job requests, slave = the sequencer.
interface vertical_chain_ctrl_if #(
  parameter int unsigned N_NODES   = 8,
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 start_i;
  logic                 abort_i;
  logic [CNT_WIDTH-1:0] num_pass_i;
  logic [N_NODES-1:0]   en_mask_i;
  logic [N_NODES-1:0]   node_rst_o;
  logic [N_NODES-1:0]   node_ld_o;
  logic [N_NODES-1:0]   en_adder_rst_o;
  logic [N_NODES-1:0]   en_adder_ld_o;
  logic [N_NODES-1:0]   en_adder_o;
  logic                 out_valid_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    output start_i, abort_i, num_pass_i, en_mask_i,
    input  node_rst_o, node_ld_o, en_adder_rst_o, en_adder_ld_o, en_adder_o,
    input  out_valid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i, num_pass_i, en_mask_i,
    output node_rst_o, node_ld_o, en_adder_rst_o, en_adder_ld_o, en_adder_o,
    output out_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/vertical_chain_ctrl.sv
// Column sequencer: clear, configure adder enables, then push a diagonal load
// wavefront down the node chain and flag column outputs / completion.
module vertical_chain_ctrl #(
  parameter int unsigned N_NODES   = 8,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  vertical_chain_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CONFIG,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [N_NODES-1:0]   wave_q, wave_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] pass_q, pass_d;
  logic [N_NODES-1:0]   mask_q, mask_d;
  logic [N_NODES-1:0]   node_rst_q, node_rst_d;
  logic [N_NODES-1:0]   en_rst_q, en_rst_d;
  logic [N_NODES-1:0]   en_ld_q, en_ld_d;
  logic [N_NODES-1:0]   en_adder_q, en_adder_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] cnt_inc;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      wave_q      <= '0;
      cnt_q       <= '0;
      pass_q      <= '0;
      mask_q      <= '0;
      node_rst_q  <= '0;
      en_rst_q    <= '0;
      en_ld_q     <= '0;
      en_adder_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wave_q      <= wave_d;
      cnt_q       <= cnt_d;
      pass_q      <= pass_d;
      mask_q      <= mask_d;
      node_rst_q  <= node_rst_d;
      en_rst_q    <= en_rst_d;
      en_ld_q     <= en_ld_d;
      en_adder_q  <= en_adder_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Outputs are computed for the state being entered so they line up with it.
  always_comb begin
    state_d     = state_q;
    wave_d      = {wave_q[N_NODES-2:0], 1'b0};
    cnt_d       = cnt_q;
    pass_d      = pass_q;
    mask_d      = mask_q;
    node_rst_d  = '0;
    en_rst_d    = '0;
    en_ld_d     = '0;
    en_adder_d  = en_adder_q;
    out_valid_d = wave_q[N_NODES-1];
    done_d      = 1'b0;
    cnt_inc     = cnt_q + CNT_WIDTH'(1);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          pass_d     = bus.num_pass_i;
          mask_d     = bus.en_mask_i;
          state_d    = S_CLEAR;
          node_rst_d = '1;
          en_rst_d   = '1;
          en_adder_d = '0;
        end
      end
      S_CLEAR: begin
        state_d    = S_CONFIG;
        en_ld_d    = '1;
        en_adder_d = mask_q;
      end
      S_CONFIG: begin
        cnt_d = '0;
        if (pass_q != '0) begin
          state_d   = S_RUN;
          wave_d[0] = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        // Counter stops at P; the last injected word leaves with wave[0]=0.
        if (cnt_inc == pass_q) begin
          state_d = S_DRAIN;
        end else begin
          wave_d[0] = 1'b1;
        end
      end
      S_DRAIN: begin
        if ((wave_q == '0) && out_valid_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort leaves node contents and adder enables untouched; next CLEAR wipes them.
    if ((state_q != S_IDLE) && bus.abort_i) begin
      state_d     = S_IDLE;
      wave_d      = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      node_rst_d  = '0;
      en_rst_d    = '0;
      en_ld_d     = '0;
      en_adder_d  = en_adder_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.node_rst_o     = node_rst_q;
  assign bus.node_ld_o      = wave_q;
  assign bus.en_adder_rst_o = en_rst_q;
  assign bus.en_adder_ld_o  = en_ld_q;
  assign bus.en_adder_o     = en_adder_q;
  assign bus.out_valid_o    = out_valid_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;

endmodule
